// File: rtl/mult_pipe_gznk.sv
// Pipelined multiplier: operands captured on the accepting edge, then LAT stages each retire
// WIDTH/LAT multiplier bits into a running partial sum; the last stage is the output register.
module mult_pipe_gznk #(
  parameter int WIDTH = 32,
  parameter int LAT   = 4,
  parameter int USR   = 5
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             io_stop,
  input  logic             io_flush,
  input  logic             io_in_en,
  input  logic [WIDTH-1:0] io_in1,
  input  logic [WIDTH-1:0] io_in2,
  input  logic             io_sign1,
  input  logic             io_sign2,
  input  logic [USR-1:0]   io_in_usr,
  output logic [WIDTH-1:0] io_result_l,
  output logic [WIDTH-1:0] io_result_h,
  output logic [USR-1:0]   io_out_usr,
  output logic             io_out_en
);

  localparam int CH = WIDTH / LAT;
  localparam int PW = 2 * WIDTH;

  logic             in_vld_q;
  logic [WIDTH-1:0] in_a_q;
  logic [WIDTH-1:0] in_b_q;
  logic             in_s1_q;
  logic             in_s2_q;
  logic [USR-1:0]   in_usr_q;

  // Flush wins over stall; a stall ignores io_in_en entirely.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      in_vld_q <= 1'b0;
      in_a_q   <= '0;
      in_b_q   <= '0;
      in_s1_q  <= 1'b0;
      in_s2_q  <= 1'b0;
      in_usr_q <= '0;
    end else if (io_flush) begin
      in_vld_q <= 1'b0;
    end else if (!io_stop) begin
      in_vld_q <= io_in_en;
      in_a_q   <= io_in1;
      in_b_q   <= io_in2;
      in_s1_q  <= io_sign1;
      in_s2_q  <= io_sign2;
      in_usr_q <= io_in_usr;
    end
  end

  logic [LAT-1:0]   src_vld;
  logic             src_s1  [LAT];
  logic             src_s2  [LAT];
  logic [WIDTH-1:0] src_a   [LAT];
  logic [WIDTH-1:0] src_b   [LAT];
  logic [USR-1:0]   src_usr [LAT];
  logic [PW-1:0]    src_acc [LAT];
  logic [PW-1:0]    a_ext   [LAT];
  logic [PW-1:0]    corr    [LAT];
  logic [PW-1:0]    nxt_acc [LAT];

  logic [LAT-1:0]   st_vld;
  logic             st_s1   [LAT];
  logic             st_s2   [LAT];
  logic [WIDTH-1:0] st_a    [LAT];
  logic [WIDTH-1:0] st_b    [LAT];
  logic [USR-1:0]   st_usr  [LAT];
  logic [PW-1:0]    st_acc  [LAT];

  for (genvar k = 0; k < LAT; k++) begin : g_stage
    if (k == 0) begin : g_src
      assign src_vld[k] = in_vld_q;
      assign src_s1[k]  = in_s1_q;
      assign src_s2[k]  = in_s2_q;
      assign src_a[k]   = in_a_q;
      assign src_b[k]   = in_b_q;
      assign src_usr[k] = in_usr_q;
      assign src_acc[k] = '0;
    end else begin : g_src
      assign src_vld[k] = st_vld[k-1];
      assign src_s1[k]  = st_s1[k-1];
      assign src_s2[k]  = st_s2[k-1];
      assign src_a[k]   = st_a[k-1];
      assign src_b[k]   = st_b[k-1];
      assign src_usr[k] = st_usr[k-1];
      assign src_acc[k] = st_acc[k-1];
    end

    assign a_ext[k] = {{WIDTH{src_s1[k] & src_a[k][WIDTH-1]}}, src_a[k]};

    // Chunks treat the multiplier as unsigned; a negative multiplier weighs -2^WIDTH more,
    // which the last stage folds in as a subtraction of the shifted multiplicand.
    if (k == LAT - 1) begin : g_corr
      assign corr[k] = (src_s2[k] && src_b[k][WIDTH-1]) ?
                       ({PW{1'b0}} - (a_ext[k] << WIDTH)) : '0;
    end else begin : g_corr
      assign corr[k] = '0;
    end

    assign nxt_acc[k] = src_acc[k] + corr[k] +
                        ((a_ext[k] * PW'(src_b[k][k*CH +: CH])) << (k * CH));
  end

  // Output stage data only moves on a real completion so it holds the last delivered result.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      st_vld <= '0;
      for (int k = 0; k < LAT; k++) begin
        st_s1[k]  <= 1'b0;
        st_s2[k]  <= 1'b0;
        st_a[k]   <= '0;
        st_b[k]   <= '0;
        st_usr[k] <= '0;
        st_acc[k] <= '0;
      end
    end else if (io_flush) begin
      st_vld <= '0;
    end else if (!io_stop) begin
      st_vld <= src_vld;
      for (int k = 0; k < LAT; k++) begin
        st_s1[k] <= src_s1[k];
        st_s2[k] <= src_s2[k];
        st_a[k]  <= src_a[k];
        st_b[k]  <= src_b[k];
        if (k < LAT - 1 || src_vld[k]) begin
          st_usr[k] <= src_usr[k];
          st_acc[k] <= nxt_acc[k];
        end
      end
    end
  end

  assign io_out_en   = st_vld[LAT-1];
  assign io_result_l = st_acc[LAT-1][WIDTH-1:0];
  assign io_result_h = st_acc[LAT-1][PW-1:WIDTH];
  assign io_out_usr  = st_usr[LAT-1];

endmodule

// File: tb/tb_mult_pipe_gznk.sv
// Bench for mult_pipe_gznk: four parameter sets driven in lockstep, directed vectors and
// sequences plus a random stream checked against an accept-time/due-time scoreboard.
module tb_mult_pipe_gznk;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n, stop, flush, in_en, s1, s2;
  logic [63:0] a, b;
  logic [4:0]  usr;

  logic [31:0] l0, h0;
  logic [15:0] l1, h1;
  logic [63:0] l2, h2;
  logic [23:0] l3, h3;
  logic [4:0]  u0, u1, u2, u3;
  logic        e0, e1, e2, e3;

  mult_pipe_gznk #(.WIDTH(32), .LAT(4), .USR(5)) dut0 (
    .clock(clk), .reset(rst_n), .io_stop(stop), .io_flush(flush), .io_in_en(in_en),
    .io_in1(a[31:0]), .io_in2(b[31:0]), .io_sign1(s1), .io_sign2(s2), .io_in_usr(usr),
    .io_result_l(l0), .io_result_h(h0), .io_out_usr(u0), .io_out_en(e0));
  mult_pipe_gznk #(.WIDTH(16), .LAT(1), .USR(5)) dut1 (
    .clock(clk), .reset(rst_n), .io_stop(stop), .io_flush(flush), .io_in_en(in_en),
    .io_in1(a[15:0]), .io_in2(b[15:0]), .io_sign1(s1), .io_sign2(s2), .io_in_usr(usr),
    .io_result_l(l1), .io_result_h(h1), .io_out_usr(u1), .io_out_en(e1));
  mult_pipe_gznk #(.WIDTH(64), .LAT(8), .USR(5)) dut2 (
    .clock(clk), .reset(rst_n), .io_stop(stop), .io_flush(flush), .io_in_en(in_en),
    .io_in1(a), .io_in2(b), .io_sign1(s1), .io_sign2(s2), .io_in_usr(usr),
    .io_result_l(l2), .io_result_h(h2), .io_out_usr(u2), .io_out_en(e2));
  mult_pipe_gznk #(.WIDTH(24), .LAT(3), .USR(5)) dut3 (
    .clock(clk), .reset(rst_n), .io_stop(stop), .io_flush(flush), .io_in_en(in_en),
    .io_in1(a[23:0]), .io_in2(b[23:0]), .io_sign1(s1), .io_sign2(s2), .io_in_usr(usr),
    .io_result_l(l3), .io_result_h(h3), .io_out_usr(u3), .io_out_en(e3));

  logic [127:0] got_p [4];
  logic [4:0]   got_u [4];
  logic         got_e [4];
  assign got_p[0] = {64'd0, h0, l0};
  assign got_p[1] = {96'd0, h1, l1};
  assign got_p[2] = {h2, l2};
  assign got_p[3] = {80'd0, h3, l3};
  assign got_u[0] = u0;
  assign got_u[1] = u1;
  assign got_u[2] = u2;
  assign got_u[3] = u3;
  assign got_e[0] = e0;
  assign got_e[1] = e1;
  assign got_e[2] = e2;
  assign got_e[3] = e3;

  localparam int WS [4] = '{32, 16, 64, 24};
  localparam int LS [4] = '{4, 1, 8, 3};

  typedef struct {
    int unsigned n;
    logic [63:0] a;
    logic [63:0] b;
    logic        s1;
    logic        s2;
    logic [4:0]  usr;
  } op_t;

  op_t          ops [4096];
  int           wr;
  int           head [4];
  int unsigned  ncnt;
  int           accepted;
  logic [127:0] exp_p [4];
  logic [4:0]   exp_u [4];
  logic         exp_e [4];
  int           checks, errors;

  function automatic logic [131:0] ext(input int w, input logic [63:0] v, input logic s);
    logic [131:0] r;
    r = {68'd0, v} & ((132'd1 << w) - 132'd1);
    if (s && v[w-1]) r = r - (132'd1 << w);
    return r;
  endfunction

  function automatic logic [127:0] ref_prod(input int w, input logic [63:0] x,
                                            input logic [63:0] y, input logic sx,
                                            input logic sy);
    logic [131:0] p;
    p = ext(w, x, sx) * ext(w, y, sy);
    p = p & ((132'd1 << (2 * w)) - 132'd1);
    return p[127:0];
  endfunction

  task automatic chk(input string name, input logic [127:0] got, input logic [127:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got %h, expected %h", name, got, want);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 4; i++) begin
      head[i]  = wr;
      exp_e[i] = 1'b0;
      exp_p[i] = '0;
      exp_u[i] = '0;
    end
  endtask

  // An op accepted when the unstalled-edge count reaches n is visible once it reaches n+LAT.
  task automatic model_edge();
    if (!rst_n) begin
      model_reset();
    end else if (flush) begin
      for (int i = 0; i < 4; i++) begin
        head[i]  = wr;
        exp_e[i] = 1'b0;
      end
    end else if (!stop) begin
      ncnt++;
      for (int i = 0; i < 4; i++) begin
        if (head[i] < wr && ops[head[i]].n + LS[i] == ncnt) begin
          exp_e[i] = 1'b1;
          exp_p[i] = ref_prod(WS[i], ops[head[i]].a, ops[head[i]].b, ops[head[i]].s1,
                              ops[head[i]].s2);
          exp_u[i] = ops[head[i]].usr;
          head[i]++;
        end else begin
          exp_e[i] = 1'b0;
        end
      end
      if (in_en) begin
        if (wr >= 4096) begin
          $display("FAIL scoreboard overflow: got %0d entries, expected below 4096", wr);
          $fatal(1);
        end
        ops[wr] = '{ncnt, a, b, s1, s2, usr};
        wr++;
        accepted++;
      end
    end
  endtask

  task automatic check_all();
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("inst%0d out_en", i), 128'(got_e[i]), 128'(exp_e[i]));
      chk($sformatf("inst%0d result", i), got_p[i], exp_p[i]);
      chk($sformatf("inst%0d out_usr", i), 128'(got_u[i]), 128'(exp_u[i]));
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_edge();
    #1;
    check_all();
  endtask

  task automatic idle(input int n);
    in_en = 1'b0;
    stop  = 1'b0;
    flush = 1'b0;
    repeat (n) tick();
  endtask

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic        s1;
    logic        s2;
    logic [63:0] p;
  } vec_t;

  vec_t tv [10];
  int   tag, cyc;
  logic [127:0] snap_p;
  logic [4:0]   snap_u;

  initial begin
    tv[0] = '{32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0, 1'b0, 64'hFFFFFFFE_00000001};
    tv[1] = '{32'hFFFFFFFF, 32'h00000002, 1'b1, 1'b1, 64'hFFFFFFFF_FFFFFFFE};
    tv[2] = '{32'h80000000, 32'h00000002, 1'b1, 1'b0, 64'hFFFFFFFF_00000000};
    tv[3] = '{32'h80000000, 32'h00000002, 1'b0, 1'b0, 64'h00000001_00000000};
    tv[4] = '{32'h00000002, 32'hFFFFFFFF, 1'b0, 1'b1, 64'hFFFFFFFF_FFFFFFFE};
    tv[5] = '{32'hFFFFFFFF, 32'hFFFFFFFF, 1'b1, 1'b1, 64'h00000000_00000001};
    tv[6] = '{32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0, 1'b1, 64'hFFFFFFFF_00000001};
    tv[7] = '{32'h80000000, 32'h80000000, 1'b1, 1'b1, 64'h40000000_00000000};
    tv[8] = '{32'h00000000, 32'hFFFFFFFF, 1'b1, 1'b1, 64'h00000000_00000000};
    tv[9] = '{32'h7FFFFFFF, 32'h80000000, 1'b1, 1'b1, 64'hC0000000_80000000};

    checks = 0; errors = 0; wr = 0; ncnt = 0; accepted = 0;
    stop = 0; flush = 0; in_en = 0; s1 = 0; s2 = 0; a = '0; b = '0; usr = '0;
    rst_n = 1'b1;
    model_reset();
    #1 rst_n = 1'b0;
    #11;
    check_all();
    rst_n = 1'b1;

    // Directed vectors; the first is accepted on the first edge after reset release.
    for (int i = 0; i < 10; i++) begin
      a = {32'h0, tv[i].a}; b = {32'h0, tv[i].b}; s1 = tv[i].s1; s2 = tv[i].s2;
      usr = 5'(i + 1); in_en = 1'b1;
      tick();
      in_en = 1'b0;
      repeat (4) tick();
      chk($sformatf("vec%0d out_en", i), 128'(e0), 128'(1'b1));
      chk($sformatf("vec%0d product", i), {64'd0, h0, l0}, {64'd0, tv[i].p});
      chk($sformatf("vec%0d tag", i), 128'(u0), 128'(5'(i + 1)));
    end
    idle(12);

    // Tags 1..8 back to back with a 3-cycle stall after the first two are accepted.
    tag = 1;
    for (int e = 0; e <= 16; e++) begin
      stop = (e >= 2 && e <= 4);
      in_en = (tag <= 8);
      usr = 5'(tag);
      a = {$urandom, $urandom}; b = {$urandom, $urandom};
      s1 = 1'($urandom); s2 = 1'($urandom);
      tick();
      if (!stop && in_en) tag++;
      if (e >= 7 && e <= 14) begin
        chk($sformatf("stall seq edge%0d out_en", e), 128'(e0), 128'(1'b1));
        chk($sformatf("stall seq edge%0d tag", e), 128'(u0), 128'(e - 6));
      end else begin
        chk($sformatf("stall seq edge%0d out_en", e), 128'(e0), 128'(1'b0));
      end
      if (e == 1) begin
        snap_p = {64'd0, h0, l0};
        snap_u = u0;
      end
      if (e >= 2 && e <= 4) begin
        chk($sformatf("stall hold edge%0d result", e), {64'd0, h0, l0}, snap_p);
        chk($sformatf("stall hold edge%0d tag", e), 128'(u0), 128'(snap_u));
      end
    end
    idle(12);

    // Three in flight, then flush together with a new op: nothing may complete.
    for (int e = 0; e <= 15; e++) begin
      in_en = (e <= 3);
      flush = (e == 3);
      usr = 5'(20 + e);
      a = {$urandom, $urandom}; b = {$urandom, $urandom};
      tick();
      flush = 1'b0;
      chk($sformatf("flush edge%0d inst0 out_en", e), 128'(e0), 128'(1'b0));
      chk($sformatf("flush edge%0d inst2 out_en", e), 128'(e2), 128'(1'b0));
      chk($sformatf("flush edge%0d inst3 out_en", e), 128'(e3), 128'(1'b0));
    end
    idle(12);

    // Reset pulse between edges with two ops in flight.
    for (int e = 0; e < 2; e++) begin
      in_en = 1'b1; usr = 5'(28 + e);
      a = {$urandom, $urandom}; b = {$urandom, $urandom};
      tick();
    end
    in_en = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    model_reset();
    check_all();
    chk("async reset result", {64'd0, h0, l0}, 128'd0);
    #1 rst_n = 1'b1;
    for (int e = 0; e < 12; e++) begin
      tick();
      chk($sformatf("post reset edge%0d out_en", e), 128'(e0), 128'(1'b0));
    end

    // Random stream with stalls, occasional flushes and random sign modes.
    begin
      int start;
      start = accepted;
      cyc = 0;
      while (accepted - start < 1000 && cyc < 8000) begin
        in_en = ($urandom_range(3) != 0);
        stop  = ($urandom_range(5) == 0);
        flush = ($urandom_range(63) == 0);
        s1 = 1'($urandom); s2 = 1'($urandom);
        usr = 5'($urandom);
        a = {$urandom, $urandom}; b = {$urandom, $urandom};
        tick();
        cyc++;
      end
      checks++;
      if (accepted - start < 1000) begin
        errors++;
        $display("FAIL random budget: got %0d accepted, expected 1000", accepted - start);
      end
    end
    idle(12);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
